// File: rtl/pong_game_ctrl_pkg.sv
// Shared definitions for the pong game controller: state codes, player ids and defaults.
package pong_game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } game_state_e;

  typedef enum logic {
    PLAYER_A = 1'b0,
    PLAYER_B = 1'b1
  } player_e;

  localparam int unsigned WIN_SCORE_DEFAULT   = 7;
  localparam int unsigned WAIT_CYCLES_DEFAULT = 200_000_000;

endpackage

// File: rtl/pong_wait_timer.sv
// Pause timer: counts 0..WAIT_CYCLES-1 while enabled; done flags the terminal count
// and the counter wraps to zero on that same edge.
module pong_wait_timer #(
  parameter int unsigned WAIT_CYCLES = 200_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] count_q;

  assign done = en && (count_q == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr || done) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-level controller for two-player pong: scoring, serve/pause sequencing and
// game-over detection, feeding pong_graph (gra_still) and the score overlay.
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = WIN_SCORE_DEFAULT,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       hit_A,
  input  logic       hit_B,
  input  logic       miss,
  output logic       gra_still,
  output logic [3:0] score_A,
  output logic [3:0] score_B,
  output logic [1:0] state_o,
  output logic       winner_A,
  output logic       point_pulse
);

  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  game_state_e state_q;
  player_e     last_hit_q;
  logic        btn_q;
  logic [3:0]  score_a_q;
  logic [3:0]  score_b_q;
  logic        winner_a_q;
  logic        point_pulse_q;

  logic        start_edge;
  logic        timer_en;
  logic        timer_done;
  player_e     scorer;
  logic [3:0]  scorer_pts;
  logic [3:0]  scorer_pts_d;

  assign start_edge = btn_start & ~btn_q;

  // A hit in the very cycle the ball goes out still credits that player.
  assign scorer       = hit_A ? PLAYER_A : (hit_B ? PLAYER_B : last_hit_q);
  assign scorer_pts   = (scorer == PLAYER_A) ? score_a_q : score_b_q;
  assign scorer_pts_d = (scorer_pts < WIN) ? scorer_pts + 4'd1 : WIN;

  assign timer_en = (state_q == ST_NEWBALL) || (state_q == ST_OVER);

  pong_wait_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (~timer_en),
    .en   (timer_en),
    .done (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_NEWGAME;
      last_hit_q    <= PLAYER_A;
      btn_q         <= 1'b0;
      score_a_q     <= 4'd0;
      score_b_q     <= 4'd0;
      winner_a_q    <= 1'b0;
      point_pulse_q <= 1'b0;
    end else begin
      btn_q         <= btn_start;
      point_pulse_q <= 1'b0;
      case (state_q)
        ST_NEWGAME: begin
          score_a_q <= 4'd0;
          score_b_q <= 4'd0;
          if (start_edge) begin
            state_q    <= ST_PLAY;
            last_hit_q <= PLAYER_A;
          end
        end
        ST_PLAY: begin
          if (miss) begin
            point_pulse_q <= 1'b1;
            if (scorer == PLAYER_A) score_a_q <= scorer_pts_d;
            else                    score_b_q <= scorer_pts_d;
            if (scorer_pts_d == WIN) begin
              state_q    <= ST_OVER;
              winner_a_q <= (scorer == PLAYER_A);
            end else begin
              state_q <= ST_NEWBALL;
            end
          end else if (hit_A) begin
            last_hit_q <= PLAYER_A;
          end else if (hit_B) begin
            last_hit_q <= PLAYER_B;
          end
        end
        ST_NEWBALL: begin
          // Serve heads toward B, so an unreturned serve is A's point.
          if (timer_done) begin
            state_q    <= ST_PLAY;
            last_hit_q <= PLAYER_A;
          end
        end
        ST_OVER: begin
          if (timer_done) begin
            state_q   <= ST_NEWGAME;
            score_a_q <= 4'd0;
            score_b_q <= 4'd0;
          end
        end
      endcase
    end
  end

  assign gra_still   = (state_q != ST_PLAY);
  assign state_o     = state_q;
  assign score_A     = score_a_q;
  assign score_B     = score_b_q;
  assign winner_A    = winner_a_q;
  assign point_pulse = point_pulse_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with WAIT_CYCLES=10, WIN_SCORE=3.
module tb_pong_game_ctrl;

  localparam int unsigned WAIT = 10;
  localparam int unsigned WIN  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_start = 1'b0;
  logic       hit_A = 1'b0;
  logic       hit_B = 1'b0;
  logic       miss = 1'b0;
  logic       gra_still;
  logic [3:0] score_A;
  logic [3:0] score_B;
  logic [1:0] state_o;
  logic       winner_A;
  logic       point_pulse;

  int vectors = 0;
  int miscompares = 0;

  pong_game_ctrl #(
    .WIN_SCORE  (WIN),
    .WAIT_CYCLES(WAIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_start  (btn_start),
    .hit_A      (hit_A),
    .hit_B      (hit_B),
    .miss       (miss),
    .gra_still  (gra_still),
    .score_A    (score_A),
    .score_B    (score_B),
    .state_o    (state_o),
    .winner_A   (winner_A),
    .point_pulse(point_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits at negedges until state_o reaches exp, bounded by budget cycles.
  task automatic wait_state(input logic [1:0] exp, input int budget, input string name);
    int n = 0;
    while (state_o !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (state_o !== exp) begin
      miscompares++;
      $display("FAIL %s: state_o=%b expected %b after %0d cycles", name, state_o, exp, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      vectors++;
      if ({state_o, gra_still, score_A, score_B, point_pulse} !== {2'b00, 1'b1, 4'd0, 4'd0, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: state=%b still=%b A=%0d B=%0d pulse=%b expected 00 1 0 0 0",
                 i, state_o, gra_still, score_A, score_B, point_pulse);
      end
    end
  endtask

  task automatic test_start();
    btn_start = 1'b1;
    @(negedge clk);
    vectors++;
    if ({state_o, gra_still} !== {2'b01, 1'b0}) begin
      miscompares++;
      $display("FAIL start: state=%b still=%b expected 01 0", state_o, gra_still);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({state_o, gra_still, point_pulse} !== {2'b01, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL start_hold[%0d]: state=%b still=%b pulse=%b expected 01 0 0",
                 i, state_o, gra_still, point_pulse);
      end
    end
    btn_start = 1'b0;
  endtask

  task automatic test_miss_a();
    int pulses = 0;
    miss = 1'b1;
    for (int i = 0; i < int'(WAIT); i++) begin
      @(negedge clk);
      pulses += int'(point_pulse);
      vectors++;
      if ({state_o, gra_still} !== {2'b10, 1'b1}) begin
        miscompares++;
        $display("FAIL miss_a_newball[%0d]: state=%b still=%b expected 10 1", i, state_o, gra_still);
      end
      if (i == 0) begin
        vectors++;
        if ({score_A, score_B, point_pulse} !== {4'd1, 4'd0, 1'b1}) begin
          miscompares++;
          $display("FAIL miss_a_score: A=%0d B=%0d pulse=%b expected 1 0 1", score_A, score_B, point_pulse);
        end
      end
      if (i == 4) miss = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if ({state_o, score_A, score_B} !== {2'b01, 4'd1, 4'd0} || pulses != 1) begin
      miscompares++;
      $display("FAIL miss_a_resume: state=%b A=%0d B=%0d pulses=%0d expected 01 1 0 1",
               state_o, score_A, score_B, pulses);
    end
  endtask

  task automatic test_hit_b();
    hit_B = 1'b1;
    @(negedge clk);
    hit_B = 1'b0;
    @(negedge clk);
    miss = 1'b1;
    @(negedge clk);
    miss = 1'b0;
    vectors++;
    if ({state_o, score_A, score_B, point_pulse} !== {2'b10, 4'd1, 4'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL hit_b_point: state=%b A=%0d B=%0d pulse=%b expected 10 1 1 1",
               state_o, score_A, score_B, point_pulse);
    end
    wait_state(2'b01, 20, "hit_b_resume");
  endtask

  task automatic test_same_cycle();
    hit_B = 1'b1;
    @(negedge clk);
    hit_B = 1'b0;
    hit_A = 1'b1;
    miss  = 1'b1;
    @(negedge clk);
    hit_A = 1'b0;
    miss  = 1'b0;
    vectors++;
    if ({state_o, score_A, score_B, point_pulse} !== {2'b10, 4'd2, 4'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL same_cycle_hit: state=%b A=%0d B=%0d pulse=%b expected 10 2 1 1",
               state_o, score_A, score_B, point_pulse);
    end
    wait_state(2'b01, 20, "same_cycle_resume");
  endtask

  task automatic test_game_over();
    miss = 1'b1;
    @(negedge clk);
    miss = 1'b0;
    btn_start = 1'b1;
    vectors++;
    if ({state_o, gra_still, score_A, winner_A, point_pulse} !== {2'b11, 1'b1, 4'd3, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL over_entry: state=%b still=%b A=%0d winA=%b pulse=%b expected 11 1 3 1 1",
               state_o, gra_still, score_A, winner_A, point_pulse);
    end
    for (int i = 1; i < int'(WAIT); i++) begin
      @(negedge clk);
      vectors++;
      if (state_o !== 2'b11) begin
        miscompares++;
        $display("FAIL over_dwell[%0d]: state=%b expected 11", i, state_o);
      end
    end
    @(negedge clk);
    vectors++;
    if ({state_o, score_A, score_B, winner_A} !== {2'b00, 4'd0, 4'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL over_exit: state=%b A=%0d B=%0d winA=%b expected 00 0 0 1",
               state_o, score_A, score_B, winner_A);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (state_o !== 2'b00) begin
        miscompares++;
        $display("FAIL held_btn[%0d]: state=%b expected 00", i, state_o);
      end
    end
    btn_start = 1'b0;
    @(negedge clk);
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    vectors++;
    if ({state_o, score_A, score_B} !== {2'b01, 4'd0, 4'd0}) begin
      miscompares++;
      $display("FAIL restart: state=%b A=%0d B=%0d expected 01 0 0", state_o, score_A, score_B);
    end
  endtask

  task automatic test_b_wins();
    for (int k = 1; k <= int'(WIN); k++) begin
      hit_B = 1'b1;
      @(negedge clk);
      hit_B = 1'b0;
      miss  = 1'b1;
      @(negedge clk);
      miss  = 1'b0;
      vectors++;
      if (k < int'(WIN)) begin
        if ({state_o, score_A, score_B} !== {2'b10, 4'd0, 4'(k)}) begin
          miscompares++;
          $display("FAIL b_point[%0d]: state=%b A=%0d B=%0d expected 10 0 %0d", k, state_o, score_A, score_B, k);
        end
        wait_state(2'b01, 20, "b_point_resume");
      end else begin
        if ({state_o, score_A, score_B, winner_A} !== {2'b11, 4'd0, 4'd3, 1'b0}) begin
          miscompares++;
          $display("FAIL b_wins: state=%b A=%0d B=%0d winA=%b expected 11 0 3 0",
                   state_o, score_A, score_B, winner_A);
        end
      end
    end
    wait_state(2'b00, 20, "b_wins_newgame");
    vectors++;
    if ({score_A, score_B, winner_A} !== {4'd0, 4'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL b_wins_clear: A=%0d B=%0d winA=%b expected 0 0 0", score_A, score_B, winner_A);
    end
  endtask

  task automatic test_reset_mid();
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    miss = 1'b1;
    @(negedge clk);
    miss = 1'b0;
    vectors++;
    if ({state_o, score_A} !== {2'b10, 4'd1}) begin
      miscompares++;
      $display("FAIL mid_setup: state=%b A=%0d expected 10 1", state_o, score_A);
    end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if ({state_o, gra_still, score_A, score_B, point_pulse, dut.u_timer.count_q} !==
        {2'b00, 1'b1, 4'd0, 4'd0, 1'b0, 4'd0}) begin
      miscompares++;
      $display("FAIL mid_reset: state=%b still=%b A=%0d B=%0d pulse=%b timer=%0d expected 00 1 0 0 0 0",
               state_o, gra_still, score_A, score_B, point_pulse, dut.u_timer.count_q);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({state_o, score_A} !== {2'b00, 4'd0}) begin
      miscompares++;
      $display("FAIL mid_after: state=%b A=%0d expected 00 0", state_o, score_A);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_miss_a();
    test_hit_b();
    test_same_cycle();
    test_game_over();
    test_b_wins();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
